// File: rtl/bithash_pkg.sv
// Shared types and widths for the nonce sweep datapath.
package bithash_pkg;

    localparam int NONCE_W     = 32;
    localparam int HASH_W      = 256;
    localparam int CMP_LATENCY = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_HASH,
        S_COMPARE
    } sweep_state_t;

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Hash core / comparator handshake bundle driven by the sweep controller.
interface nonce_sweep_ctrl_if;
    import bithash_pkg::*;

    logic [NONCE_W-1:0] nonce;
    logic               hash_start;
    logic               hash_ready;
    logic               cmp_en;
    logic               cmp_done;
    logic               cmp_end_nonce;
    logic [HASH_W-1:0]  cmp_hash;

    modport master (
        output nonce, hash_start, cmp_en,
        input  hash_ready, cmp_done, cmp_end_nonce, cmp_hash
    );

    modport slave (
        input  nonce, hash_start, cmp_en,
        output hash_ready, cmp_done, cmp_end_nonce, cmp_hash
    );

endinterface

// File: rtl/nonce_range_counter.sv
// Current nonce and inclusive end register; last is true when the current
// nonce equals the end value, so wrapped ranges need no special handling.
module nonce_range_counter
    import bithash_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               inc,
    input  logic [NONCE_W-1:0] start_val,
    input  logic [NONCE_W-1:0] end_val,
    output logic [NONCE_W-1:0] nonce,
    output logic               last
);

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;

    always_comb begin
        nonce_d = nonce_q;
        end_d   = end_q;
        if (load) begin
            nonce_d = start_val;
            end_d   = end_val;
        end else if (inc) begin
            nonce_d = nonce_q + NONCE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q <= '0;
            end_q   <= '0;
        end else begin
            nonce_q <= nonce_d;
            end_q   <= end_d;
        end
    end

    assign nonce = nonce_q;
    assign last  = (nonce_q == end_q);

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweep FSM: launches one hash per nonce, gates the comparator, and latches
// the first winning nonce/hash, range exhaustion or comparator timeout.
module nonce_sweep_ctrl
    import bithash_pkg::*;
#(
    parameter int CMP_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [NONCE_W-1:0]   nonce_end,
    nonce_sweep_ctrl_if.master   bus,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 cmp_err,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [HASH_W-1:0]    found_hash,
    output logic [31:0]          hashes_done
);

    localparam int WD_W = $clog2(CMP_TIMEOUT + 1);

    sweep_state_t        state_q, state_d;
    logic                hash_start_q, hash_start_d;
    logic                cmp_en_q, cmp_en_d;
    logic                busy_q, busy_d;
    logic                found_q, found_d;
    logic                exhausted_q, exhausted_d;
    logic                cmp_err_q, cmp_err_d;
    logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
    logic [HASH_W-1:0]   found_hash_q, found_hash_d;
    logic [31:0]         hashes_done_q, hashes_done_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    logic                cnt_load, cnt_inc, cnt_last;
    logic [NONCE_W-1:0]  cur_nonce;

    nonce_range_counter u_range (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .start_val (nonce_start),
        .end_val   (nonce_end),
        .nonce     (cur_nonce),
        .last      (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        hash_start_d  = 1'b0;
        cmp_en_d      = cmp_en_q;
        busy_d        = busy_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        cmp_err_d     = cmp_err_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        hashes_done_d = hashes_done_q;
        wd_d          = wd_q;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;

        if (abort) begin
            state_d  = S_IDLE;
            cmp_en_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_load      = 1'b1;
                        found_d       = 1'b0;
                        exhausted_d   = 1'b0;
                        cmp_err_d     = 1'b0;
                        hashes_done_d = '0;
                        busy_d        = 1'b1;
                        hash_start_d  = 1'b1;
                        state_d       = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cmp_en_d = 1'b0;
                    state_d  = S_WAIT_HASH;
                end
                S_WAIT_HASH: begin
                    if (bus.hash_ready) begin
                        cmp_en_d = 1'b1;
                        wd_d     = '0;
                        state_d  = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (bus.cmp_done) begin
                        cmp_en_d      = 1'b0;
                        hashes_done_d = hashes_done_q + 32'd1;
                        if (bus.cmp_end_nonce) begin
                            found_d       = 1'b1;
                            found_nonce_d = cur_nonce;
                            found_hash_d  = bus.cmp_hash;
                            busy_d        = 1'b0;
                            state_d       = S_IDLE;
                        end else if (cnt_last) begin
                            exhausted_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end else begin
                            cnt_inc      = 1'b1;
                            hash_start_d = 1'b1;
                            state_d      = S_LAUNCH;
                        end
                    end else if (wd_q == WD_W'(CMP_TIMEOUT - 1)) begin
                        // Fires on the CMP_TIMEOUT-th edge with cmp_en high.
                        cmp_err_d = 1'b1;
                        cmp_en_d  = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hash_start_q  <= 1'b0;
            cmp_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            cmp_err_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            hashes_done_q <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            hash_start_q  <= hash_start_d;
            cmp_en_q      <= cmp_en_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            cmp_err_q     <= cmp_err_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            hashes_done_q <= hashes_done_d;
            wd_q          <= wd_d;
        end
    end

    assign bus.nonce      = cur_nonce;
    assign bus.hash_start = hash_start_q;
    assign bus.cmp_en     = cmp_en_q;
    assign busy           = busy_q;
    assign found          = found_q;
    assign exhausted      = exhausted_q;
    assign cmp_err        = cmp_err_q;
    assign found_nonce    = found_nonce_q;
    assign found_hash     = found_hash_q;
    assign hashes_done    = hashes_done_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed and randomized sweeps; the bench plays hash core and comparator.
module tb_nonce_sweep_ctrl;
    import bithash_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_end;
    logic               busy, found, exhausted, cmp_err;
    logic [NONCE_W-1:0] found_nonce;
    logic [HASH_W-1:0]  found_hash;
    logic [31:0]        hashes_done;

    int checks   = 0;
    int failures = 0;

    nonce_sweep_ctrl_if bus();

    nonce_sweep_ctrl #(.CMP_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .bus         (bus),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .cmp_err     (cmp_err),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .hashes_done (hashes_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [HASH_W-1:0] obs, input logic [HASH_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HASH_W-1:0] rand_hash();
        logic [HASH_W-1:0] h;
        for (int unsigned k = 0; k < HASH_W / 32; k++) h[k*32 +: 32] = $urandom();
        return h;
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [31:0] e);
        nonce_start = s;
        nonce_end   = e;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hash_start", bus.hash_start, 1);
        chk("start_nonce", bus.nonce, s);
        chk("start_clr_found", found, 0);
        chk("start_clr_exh", exhausted, 0);
        chk("start_clr_err", cmp_err, 0);
        chk("start_clr_hd", hashes_done, 0);
    endtask

    // Entered in the LAUNCH cycle; leaves just after cmp_en has risen.
    task automatic hash_phase(input int lat);
        tick();
        chk("launch_pulse_once", bus.hash_start, 0);
        chk("launch_cmp_en_low", bus.cmp_en, 0);
        for (int k = 1; k < lat; k++) begin
            start       = 1'b1;
            nonce_start = $urandom();
            tick();
            chk("wait_cmp_en_low", bus.cmp_en, 0);
        end
        start          = 1'b0;
        bus.hash_ready = 1'b1;
        tick();
        bus.hash_ready = 1'b0;
        chk("cmp_en_rise", bus.cmp_en, 1);
    endtask

    // cmp_done is sampled on the CMP_LATENCY-th edge with cmp_en high.
    task automatic cmp_phase(input logic hit, input logic [HASH_W-1:0] h);
        for (int k = 1; k < CMP_LATENCY; k++) begin
            tick();
            chk("cmp_en_held", bus.cmp_en, 1);
        end
        bus.cmp_done      = 1'b1;
        bus.cmp_end_nonce = hit;
        bus.cmp_hash      = h;
        tick();
        bus.cmp_done      = 1'b0;
        bus.cmp_end_nonce = 1'b0;
        chk("cmp_en_fall", bus.cmp_en, 0);
    endtask

    // Reference: sweep covers len nonces s, s+1, ... mod 2^32; stops at index hit if hit < len.
    task automatic run_sweep(input logic [31:0] s, input int len, input int hit, input logic [HASH_W-1:0] hh, input int lat);
        int stop_idx;
        int exp_hd;
        logic [31:0] exp_n;
        logic is_hit;
        stop_idx = (hit >= 0 && hit < len) ? hit : len - 1;
        exp_hd   = stop_idx + 1;
        do_start(s, s + 32'(len - 1));
        for (int i = 0; i <= stop_idx; i++) begin
            exp_n = s + 32'(i);
            if (i > 0) begin
                chk("next_hash_start", bus.hash_start, 1);
                chk("next_nonce", bus.nonce, exp_n);
                chk("next_busy", busy, 1);
            end
            hash_phase(lat > 0 ? lat : int'($urandom_range(1, 4)));
            is_hit = (i == hit);
            cmp_phase(is_hit, is_hit ? hh : rand_hash());
            chk("hashes_done_step", hashes_done, 32'(i + 1));
        end
        chk("end_hashes_done", hashes_done, 32'(exp_hd));
        chk("end_busy", busy, 0);
        chk("end_hash_start", bus.hash_start, 0);
        if (hit >= 0 && hit < len) begin
            chk("end_found", found, 1);
            chk("end_exh", exhausted, 0);
            chk("found_nonce", found_nonce, s + 32'(hit));
            chk("found_hash", found_hash, hh);
        end else begin
            chk("end_found", found, 0);
            chk("end_exh", exhausted, 1);
        end
        chk("end_err", cmp_err, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_hash_start", bus.hash_start, 0);
    endtask

    initial begin
        logic [31:0] rs;
        int rlen;
        int rhit;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        nonce_start = '0; nonce_end = '0;
        bus.hash_ready = 1'b0; bus.cmp_done = 1'b0;
        bus.cmp_end_nonce = 1'b0; bus.cmp_hash = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_exh", exhausted, 0);
        chk("rst_err", cmp_err, 0);
        chk("rst_nonce", bus.nonce, 0);
        chk("rst_hash_start", bus.hash_start, 0);
        chk("rst_cmp_en", bus.cmp_en, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_found_hash", found_hash, 0);
        chk("rst_hd", hashes_done, 0);
        rst = 1'b0;
        tick();

        run_sweep(32'h10, 1, -1, '0, 3);
        run_sweep(32'h100, 256, 4, 256'hABC, 0);
        run_sweep(32'hFFFF_FFFE, 4, -1, '0, 2);

        for (int r = 0; r < 6; r++) begin
            rs   = (r % 2 == 0) ? $urandom() : (32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
            rlen = int'($urandom_range(1, 6));
            rhit = int'($urandom_range(0, 7));
            run_sweep(rs, rlen, rhit, rand_hash(), 0);
        end

        // Abort coincident with a winning cmp_done and a start on the 3rd compare.
        do_start(32'h500, 32'h509);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) chk("abort_nonce", bus.nonce, 32'h501);
            hash_phase(2);
            cmp_phase(1'b0, '0);
        end
        hash_phase(1);
        for (int k = 1; k < CMP_LATENCY; k++) tick();
        bus.cmp_done = 1'b1; bus.cmp_end_nonce = 1'b1; bus.cmp_hash = 256'h1234;
        abort = 1'b1; start = 1'b1;
        tick();
        bus.cmp_done = 1'b0; bus.cmp_end_nonce = 1'b0;
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cmp_en", bus.cmp_en, 0);
        chk("abort_found", found, 0);
        chk("abort_exh", exhausted, 0);
        chk("abort_hd", hashes_done, 2);
        chk("abort_hash_start", bus.hash_start, 0);
        tick();
        chk("abort_start_ignored", busy, 0);

        // Comparator never answers.
        do_start(32'h77, 32'h80);
        hash_phase(2);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("to_err_low", cmp_err, 0);
            chk("to_cmp_en", bus.cmp_en, 1);
        end
        tick();
        chk("to_err", cmp_err, 1);
        chk("to_busy", busy, 0);
        chk("to_cmp_en_low", bus.cmp_en, 0);
        chk("to_found", found, 0);
        chk("to_exh", exhausted, 0);
        chk("to_hd", hashes_done, 0);
        tick();

        // Reset while waiting for the hash core.
        do_start(32'hABCD, 32'hABD0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_nonce", bus.nonce, 0);
        chk("mrst_err", cmp_err, 0);
        chk("mrst_cmp_en", bus.cmp_en, 0);
        chk("mrst_hash_start", bus.hash_start, 0);
        chk("mrst_hd", hashes_done, 0);
        chk("mrst_found_hash", found_hash, 0);
        bus.hash_ready = 1'b1;
        tick();
        bus.hash_ready = 1'b0;
        chk("mrst_ready_ignored", bus.cmp_en, 0);
        chk("mrst_still_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
